pair_triple_scanner: RTL and testbench
======================================

PAIR_TRIPLE_SCANNER -- requirements
Module: pair_triple_scanner

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4: samples per frame; legal range 2..255.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a frame; honoured only in IDLE.
REQ-005 SHALL have port busy  output  1  high in RUN and DONE.
REQ-006 SHALL have port in_val  input  1  input sample valid.
REQ-007 SHALL have port in_rdy  output  1  block can accept a sample.
REQ-008 SHALL have port in_data  input  3  sample bits {in2,in1,in0}.
REQ-009 SHALL have port out_val  output  1  frame result valid.
REQ-010 SHALL have port out_rdy  input  1  consumer accepts result.
REQ-011 SHALL have port out_count  output  8  number of detecting samples in the frame.
REQ-012 SHALL have port out_any  output  1  at least one detecting sample in the frame.
REQ-013 SHALL have port out_maxrun  output  8  longest run of consecutive detecting samples (see Configuration).

Function
REQ-014 SHALL classify a sample as detecting when two or three of its bits are 1 (000, 001, 010 and 100 are non-detecting).
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 In IDLE: in_rdy=0, out_val=0, busy=0; start=1 moves to RUN next cycle and clears the sample index, out_count, out_any, out_maxrun and the run counter.
REQ-017 In RUN: in_rdy=1; a sample is accepted only on a cycle with in_val=1 and in_rdy=1; cycles with in_val=0 change no state.
REQ-018 On each accept: increment the sample index; increment out_count if detecting; set out_any if detecting.
REQ-019 The accept of sample number FRAME_LEN (index FRAME_LEN-1) SHALL move the FSM to DONE; out_val rises the following cycle (latency 1 from the last accept).
REQ-020 In DONE: out_val=1, in_rdy=0; out_count, out_any and out_maxrun SHALL hold stable until the handshake.
REQ-021 out_val=1 with out_rdy=1 SHALL complete the handshake and move the FSM to IDLE next cycle; results keep their values until the next start.
REQ-022 start SHALL be ignored in RUN and DONE; a start in the IDLE cycle directly after the handshake SHALL be honoured.
REQ-023 out_count SHALL never exceed FRAME_LEN; 8-bit width guarantees no overflow.
REQ-024 All outputs SHALL be registered or decoded only from FSM state; no combinational path from in_data to any output.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and drive out_count=0, out_any=0, out_maxrun=0, out_val=0, in_rdy=0 and busy=0, including when asserted mid-RUN or in DONE.
REQ-026 After rst_n deasserts, the block SHALL remain in IDLE until it sees start=1.

Configuration
REQ-027 Macro PAIR_TRIPLE_SCANNER_MAXRUN_EN SHALL gate run tracking.
REQ-028 Defined: keep a run counter that increments on a detecting accept and clears on a non-detecting accept; out_maxrun = max(out_maxrun, run counter) after each accept.
REQ-029 Undefined: no run logic is built; out_maxrun is tied to 0; all other behaviour is identical.

Verification (FRAME_LEN=4)
REQ-030 Basic frame: start, then samples 000,011,010,111 back-to-back -> out_count=2, out_any=1, out_maxrun=1 (with macro), out_val exactly 1 cycle after the 4th accept.
REQ-031 Gapped input: same samples with in_val low for 3 cycles between each -> identical results; idle cycles are not counted.
REQ-032 Backpressure: out_rdy held 0 for 5 cycles in DONE, with start pulsed meanwhile -> out_val stays 1, results stable, start ignored; FSM enters IDLE the cycle after out_rdy=1.
REQ-033 Empty result: samples 000,001,100,010 -> out_count=0, out_any=0, out_maxrun=0.
REQ-034 Run tracking: samples 110,101,011,000 -> out_count=3; out_maxrun=3 with the macro defined, 0 without it.
REQ-035 Reset mid-frame: rst_n pulsed low after 2 accepts -> all outputs 0 at once, FSM in IDLE; a new full frame then gives correct fresh counts.

Source files
------------

// File: rtl/pair_triple_scanner_if.sv
// Handshake and result bundle for pair_triple_scanner.
// The master side drives start/samples/out_rdy; the slave side is the scanner itself.
interface pair_triple_scanner_if;
  logic       start;
  logic       busy;
  logic       in_val;
  logic       in_rdy;
  logic [2:0] in_data;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_count;
  logic       out_any;
  logic [7:0] out_maxrun;

  modport master (
    output start, in_val, in_data, out_rdy,
    input  busy, in_rdy, out_val, out_count, out_any, out_maxrun
  );

  modport slave (
    input  start, in_val, in_data, out_rdy,
    output busy, in_rdy, out_val, out_count, out_any, out_maxrun
  );
endinterface

// File: rtl/pair_triple_scanner.sv
// Counts 3-bit samples with two or more bits set over a FRAME_LEN frame.
// Optional longest-run tracking is built when PAIR_TRIPLE_SCANNER_MAXRUN_EN is defined.
module pair_triple_scanner #(
  parameter int FRAME_LEN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pair_triple_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state_reg;
  logic [7:0] idx_reg;
  logic [7:0] count_reg;
  logic       any_reg;
  logic       in_rdy_reg;
  logic       out_val_reg;
  logic       busy_reg;

  logic detect;
  logic accept;
  logic frame_start;

  // Majority of three bits: exactly the "two or three ones" patterns.
  assign detect      = (bus.in_data[0] & bus.in_data[1]) |
                       (bus.in_data[0] & bus.in_data[2]) |
                       (bus.in_data[1] & bus.in_data[2]);
  assign accept      = bus.in_val & in_rdy_reg;
  assign frame_start = (state_reg == IDLE) & bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= 8'd0;
      count_reg   <= 8'd0;
      any_reg     <= 1'b0;
      in_rdy_reg  <= 1'b0;
      out_val_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg  <= RUN;
            idx_reg    <= 8'd0;
            count_reg  <= 8'd0;
            any_reg    <= 1'b0;
            in_rdy_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            idx_reg <= idx_reg + 8'd1;
            if (detect) begin
              count_reg <= count_reg + 8'd1;
              any_reg   <= 1'b1;
            end
            if (idx_reg == LAST_IDX) begin
              state_reg   <= DONE;
              in_rdy_reg  <= 1'b0;
              out_val_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          // Results stay on the outputs after the handshake until the next start.
          if (bus.out_rdy) begin
            state_reg   <= IDLE;
            out_val_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          in_rdy_reg  <= 1'b0;
          out_val_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PAIR_TRIPLE_SCANNER_MAXRUN_EN
  logic [7:0] run_reg;
  logic [7:0] maxrun_reg;
  logic [7:0] run_next;

  assign run_next = detect ? run_reg + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg    <= 8'd0;
      maxrun_reg <= 8'd0;
    end else if (frame_start) begin
      run_reg    <= 8'd0;
      maxrun_reg <= 8'd0;
    end else if ((state_reg == RUN) && accept) begin
      run_reg <= run_next;
      if (run_next > maxrun_reg) begin
        maxrun_reg <= run_next;
      end
    end
  end

  assign bus.out_maxrun = maxrun_reg;
`else
  logic unused_start;
  assign unused_start   = frame_start;
  assign bus.out_maxrun = 8'd0;
`endif

  assign bus.out_count = count_reg;
  assign bus.out_any   = any_reg;
  assign bus.in_rdy    = in_rdy_reg;
  assign bus.out_val   = out_val_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_pair_triple_scanner.sv
// Directed self-checking bench for pair_triple_scanner with FRAME_LEN=4.
// Expected run lengths follow PAIR_TRIPLE_SCANNER_MAXRUN_EN when it is defined.
module tb_pair_triple_scanner;

`ifdef PAIR_TRIPLE_SCANNER_MAXRUN_EN
  localparam bit MAXRUN_ON = 1'b1;
`else
  localparam bit MAXRUN_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  pair_triple_scanner_if bus ();

  pair_triple_scanner #(.FRAME_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [2:0] d, input int gap);
    bus.in_val  = 1'b1;
    bus.in_data = d;
    tick();
    bus.in_val  = 1'b0;
    bus.in_data = 3'b000;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic check_results(input string tag, input logic [7:0] cnt,
                               input logic any, input logic [7:0] mr);
    check({tag, "_count"}, bus.out_count, cnt);
    check({tag, "_any"}, 8'(bus.out_any), 8'(any));
    check({tag, "_maxrun"}, bus.out_maxrun, MAXRUN_ON ? mr : 8'd0);
  endtask

  task automatic handshake(input string tag);
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    check({tag, "_idle_val"}, 8'(bus.out_val), 8'd0);
    check({tag, "_idle_busy"}, 8'(bus.busy), 8'd0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.in_val  = 1'b0;
    bus.in_data = 3'b000;
    bus.out_rdy = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_val", 8'(bus.out_val), 8'd0);
    check("rst_rdy", 8'(bus.in_rdy), 8'd0);
    check("rst_busy", 8'(bus.busy), 8'd0);
    check_results("rst", 8'd0, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 8'(bus.busy), 8'd0);

    // Basic frame, back to back
    do_start();
    check("basic_busy", 8'(bus.busy), 8'd1);
    check("basic_in_rdy", 8'(bus.in_rdy), 8'd1);
    send(3'b000, 0);
    send(3'b011, 0);
    send(3'b010, 0);
    check("basic_val_early", 8'(bus.out_val), 8'd0);
    send(3'b111, 0);
    check("basic_val_lat1", 8'(bus.out_val), 8'd1);
    check("basic_done_rdy", 8'(bus.in_rdy), 8'd0);
    check_results("basic", 8'd2, 1'b1, 8'd1);
    handshake("basic");
    check_results("basic_hold", 8'd2, 1'b1, 8'd1);

    // Gapped input
    do_start();
    check("gap_cleared", bus.out_count, 8'd0);
    send(3'b000, 3);
    send(3'b011, 3);
    send(3'b010, 3);
    check("gap_val_early", 8'(bus.out_val), 8'd0);
    send(3'b111, 0);
    check("gap_val", 8'(bus.out_val), 8'd1);
    check_results("gap", 8'd2, 1'b1, 8'd1);

    // Backpressure with start pulses in DONE
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      tick();
      check("bp_val", 8'(bus.out_val), 8'd1);
      check("bp_count", bus.out_count, 8'd2);
    end
    bus.start = 1'b0;
    check_results("bp", 8'd2, 1'b1, 8'd1);
    handshake("bp");

    // Start directly after handshake; empty result frame
    do_start();
    check("restart_busy", 8'(bus.busy), 8'd1);
    send(3'b000, 0);
    send(3'b001, 0);
    send(3'b100, 0);
    send(3'b010, 0);
    check("empty_val", 8'(bus.out_val), 8'd1);
    check_results("empty", 8'd0, 1'b0, 8'd0);
    handshake("empty");

    // Run tracking
    do_start();
    send(3'b110, 0);
    send(3'b101, 0);
    send(3'b011, 0);
    send(3'b000, 0);
    check("run_val", 8'(bus.out_val), 8'd1);
    check_results("run", 8'd3, 1'b1, 8'd3);
    handshake("run");

    // Reset mid-frame
    do_start();
    send(3'b111, 0);
    send(3'b011, 0);
    check("mid_count_pre", bus.out_count, 8'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", 8'(bus.in_rdy), 8'd0);
    check("mid_rst_busy", 8'(bus.busy), 8'd0);
    check("mid_rst_val", 8'(bus.out_val), 8'd0);
    check_results("mid_rst", 8'd0, 1'b0, 8'd0);
    tick();
    rst_n = 1'b1;
    bus.in_val  = 1'b1;
    bus.in_data = 3'b111;
    tick();
    bus.in_val  = 1'b0;
    check("mid_idle_ignore", bus.out_count, 8'd0);
    do_start();
    send(3'b011, 0);
    send(3'b000, 0);
    send(3'b101, 0);
    send(3'b110, 0);
    check("fresh_val", 8'(bus.out_val), 8'd1);
    check_results("fresh", 8'd3, 1'b1, 8'd2);
    handshake("fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
